vote_session_ctrl: RTL and testbench

Sequences one ballot of a 4-member committee. It opens a collection window and accepts exactly one vote per member through per-member valid/ack handshakes. It closes the window on all-cast or on timeout, then classifies the tally through the shared 3-way rule: reject (0-1 yes), tie (exactly 2), pass (3-4). A tie triggers a bounded re-vote; the final verdict is held for a downstream consumer until acknowledged.

---
 rtl/vote_pkg.sv | 18 +
 rtl/vote_tally.sv | 22 ++
 rtl/vote_session_ctrl.sv | 123 ++++++++++++
 tb/tb_vote_session_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared definitions for the committee voting blocks: FSM states,
// one-hot verdict encodings and committee size.
package vote_pkg;

  localparam int N_VOTERS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam logic [2:0] REJECT = 3'b100;
  localparam logic [2:0] TIE    = 3'b010;
  localparam logic [2:0] PASS   = 3'b001;

endpackage

// File: rtl/vote_tally.sv
// Combinational 3-way tally of a 4-member ballot: 0-1 yes rejects,
// exactly 2 ties, 3-4 passes.
module vote_tally
  import vote_pkg::*;
(
  input  logic [N_VOTERS-1:0] ballot,
  output logic [2:0]          verdict,
  output logic [2:0]          yes_count
);

  always_comb begin
    yes_count = {2'b00, ballot[0]} + {2'b00, ballot[1]}
              + {2'b00, ballot[2]} + {2'b00, ballot[3]};
    if (yes_count <= 3'd1)
      verdict = REJECT;
    else if (yes_count == 3'd2)
      verdict = TIE;
    else
      verdict = PASS;
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// Runs one committee ballot: collects one vote per member within a timed
// window, re-votes on ties up to MAX_ROUNDS, and holds the verdict until acked.
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_ROUNDS  = 3,
  parameter int TW          = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_val,
  output logic [N_VOTERS-1:0] vote_ack,
  output logic                result_valid,
  input  logic                result_ack,
  output logic [2:0]          result,
  output logic [2:0]          yes_count,
  output logic [1:0]          round_o,
  output logic                timed_out,
  output logic                busy
);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]    LAST_ROUND = 2'(MAX_ROUNDS);

  state_t              state;
  logic [N_VOTERS-1:0] cast;
  logic [N_VOTERS-1:0] ballot;
  logic [TW-1:0]       timer;
  logic [1:0]          round;

  logic [N_VOTERS-1:0] accept;
  logic [N_VOTERS-1:0] cast_next;
  logic [2:0]          tally_verdict;
  logic [2:0]          tally_yes;

  // A member is accepted only once per round; repeat offers are dropped.
  always_comb begin
    accept    = vote_valid & ~cast;
    cast_next = cast | accept;
  end

  vote_tally u_tally (
    .ballot    (ballot & cast),
    .verdict   (tally_verdict),
    .yes_count (tally_yes)
  );

  assign round_o = round;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cast         <= '0;
      ballot       <= '0;
      timer        <= '0;
      round        <= '0;
      vote_ack     <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      yes_count    <= '0;
      timed_out    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      vote_ack <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= COLLECT;
            round  <= 2'd1;
            cast   <= '0;
            ballot <= '0;
            timer  <= '0;
            busy   <= 1'b1;
          end
        end
        COLLECT: begin
          vote_ack <= accept;
          cast     <= cast_next;
          ballot   <= (ballot & ~accept) | (vote_val & accept);
          timer    <= timer + 1'b1;
          // A full set wins over timeout, even on the final window cycle.
          if (cast_next == {N_VOTERS{1'b1}}) begin
            state     <= EVAL;
            timed_out <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            state     <= EVAL;
            timed_out <= 1'b1;
          end
        end
        EVAL: begin
          if (tally_verdict == TIE && round < LAST_ROUND) begin
            state     <= COLLECT;
            round     <= round + 2'd1;
            cast      <= '0;
            ballot    <= '0;
            timer     <= '0;
            timed_out <= 1'b0;
          end else begin
            state        <= RESULT;
            result       <= tally_verdict;
            yes_count    <= tally_yes;
            result_valid <= 1'b1;
          end
        end
        RESULT: begin
          if (result_ack) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed self-checking bench for vote_session_ctrl with hand-computed
// expected verdicts, tallies, rounds and handshake timing.
module tb_vote_session_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] vote_valid;
  logic [3:0] vote_val;
  logic [3:0] vote_ack;
  logic       result_valid;
  logic       result_ack;
  logic [2:0] result;
  logic [2:0] yes_count;
  logic [1:0] round_o;
  logic       timed_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  vote_session_ctrl #(
    .TIMEOUT_CYC (16),
    .MAX_ROUNDS  (3),
    .TW          (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vote_valid   (vote_valid),
    .vote_val     (vote_val),
    .vote_ack     (vote_ack),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .result       (result),
    .yes_count    (yes_count),
    .round_o      (round_o),
    .timed_out    (timed_out),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then land 1 time unit after the active edge.
  task automatic applyStimulus(input logic st, input logic [3:0] vv,
                               input logic [3:0] vval, input logic rack);
    start      = st;
    vote_valid = vv;
    vote_val   = vval;
    result_ack = rack;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVerdict(input string tag, input logic [2:0] res,
                              input logic [2:0] yes, input logic [1:0] rnd,
                              input logic to);
    checkOutput({tag, "_valid"}, 32'(result_valid), 32'd1);
    checkOutput({tag, "_result"}, 32'(result), 32'(res));
    checkOutput({tag, "_yes"}, 32'(yes_count), 32'(yes));
    checkOutput({tag, "_round"}, 32'(round_o), 32'(rnd));
    checkOutput({tag, "_timeout"}, 32'(timed_out), 32'(to));
  endtask

  initial begin
    int         n;
    logic [2:0] held_result;

    rst_n = 1'b0;
    start = 1'b0; vote_valid = '0; vote_val = '0; result_ack = 1'b0;
    #12;
    checkOutput("rst_ack", 32'(vote_ack), 32'd0);
    checkOutput("rst_valid", 32'(result_valid), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_round", 32'(round_o), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Fast pass: all four vote in the first COLLECT cycle.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_round", 32'(round_o), 32'd1);
    applyStimulus(1'b0, 4'b1111, 4'b1011, 1'b0);
    checkOutput("t1_ack", 32'(vote_ack), 32'hf);
    checkOutput("t1_not_yet", 32'(result_valid), 32'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    checkOutput("t1_ack_pulse", 32'(vote_ack), 32'd0);
    checkVerdict("t1", 3'b001, 3'd3, 2'd1, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
    checkOutput("t1_done_valid", 32'(result_valid), 32'd0);
    checkOutput("t1_done_busy", 32'(busy), 32'd0);

    // Timeout: only member 0 votes yes; verdict 17 edges after start.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0);
    checkOutput("t2_ack", 32'(vote_ack), 32'h1);
    n = 1;
    while (!result_valid && n < 40) begin
      applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
      n++;
    end
    checkOutput("t2_latency", 32'(n), 32'd17);
    checkVerdict("t2", 3'b100, 3'd1, 2'd1, 1'b1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);

    // Tie in every round: two re-votes, final tie in round 3.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int r = 1; r <= 3; r++) begin
      checkOutput($sformatf("t3_round%0d", r), 32'(round_o), 32'(r));
      applyStimulus(1'b0, 4'b1111, 4'b0011, 1'b0);
      applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
      if (r < 3)
        checkOutput($sformatf("t3_revote%0d", r), 32'(result_valid), 32'd0);
    end
    checkVerdict("t3", 3'b010, 3'd2, 2'd3, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);

    // Duplicate vote from member 2 is ignored and does not overwrite.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b0);
    checkOutput("t4_ack_first", 32'(vote_ack), 32'h4);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b0);
    checkOutput("t4_ack_dup", 32'(vote_ack), 32'h0);
    applyStimulus(1'b0, 4'b1011, 4'b0000, 1'b0);
    checkOutput("t4_ack_rest", 32'(vote_ack), 32'hb);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    checkVerdict("t4", 3'b100, 3'd1, 2'd1, 1'b0);

    // Verdict held while unacknowledged; start pulses are ignored.
    held_result = result;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i[0], 4'b0000, 4'b0000, 1'b0);
      checkOutput($sformatf("t5_hold_valid%0d", i), 32'(result_valid), 32'd1);
      checkOutput($sformatf("t5_hold_result%0d", i), 32'(result), 32'(held_result));
    end
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    checkOutput("t5_ack_valid", 32'(result_valid), 32'd0);
    checkOutput("t5_ack_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    checkOutput("t5_start_ignored", 32'(busy), 32'd0);
    checkOutput("t5_result_kept", 32'(result), 32'(held_result));

    // Asynchronous reset mid-collection discards partial votes.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0011, 4'b0011, 1'b0);
    checkOutput("t6_ack", 32'(vote_ack), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_ack", 32'(vote_ack), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_round", 32'(round_o), 32'd0);
    checkOutput("t6_rst_result", 32'(result), 32'd0);
    checkOutput("t6_rst_yes", 32'(yes_count), 32'd0);
    checkOutput("t6_rst_timeout", 32'(timed_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b1100, 4'b1100, 1'b0);
    checkOutput("t6_new_ack", 32'(vote_ack), 32'hc);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    checkOutput("t6_still_collect", 32'(result_valid), 32'd0);
    checkOutput("t6_still_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 4'b0011, 4'b0001, 1'b0);
    checkOutput("t6_rest_ack", 32'(vote_ack), 32'h3);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    checkVerdict("t6", 3'b001, 3'd3, 2'd1, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
